// File: rtl/cpu_pkg.sv
// Shared constants for the fetch pipeline: FSM encoding, reset PC and the flush word.
package cpu_pkg;
    localparam logic [0:0]  ST_RUN       = 1'b0;
    localparam logic [0:0]  ST_HALTED    = 1'b1;
    localparam logic [31:0] CPU_RESET_PC = 32'h0;
    localparam logic [31:0] NOP_WORD     = 32'h0;
endpackage

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter with synchronous clear and count enable.
module perf_counter (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [31:0] o_count
);
    logic [31:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_count <= 32'h0;
        else if (i_inc)
            r_count <= r_count + 32'h1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, RUN/HALTED FSM and
// the cycle/stall/redirect performance counters.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        go,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_ir,
    output logic        id_valid,
    output logic        halted,
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redir_cnt
);
    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_ir;
    logic        r_id_valid;
    logic        w_run;

    assign w_run = (r_state == ST_RUN);

    // A redirect wins over everything but reset: ID holds a wrong-path word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_id_pc    <= 32'h0;
            r_id_ir    <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (redirect) begin
            r_state    <= ST_RUN;
            r_pc       <= redirect_pc;
            r_id_ir    <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else if (!w_run) begin
            if (go)
                r_state <= ST_RUN;
        end else if (stall) begin
            r_state <= ST_RUN;
        end else if (halt_req) begin
            // Squash the halt in ID so it cannot re-trigger after resume.
            r_state    <= ST_HALTED;
            r_id_ir    <= NOP_WORD;
            r_id_valid <= 1'b0;
        end else begin
            r_pc       <= r_pc + 32'h1;
            r_id_pc    <= r_pc;
            r_id_ir    <= imem_data;
            r_id_valid <= 1'b1;
        end
    end

    perf_counter u_cyc (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_run),
        .o_count (cyc_cnt)
    );

    perf_counter u_stall (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_run && stall && !redirect),
        .o_count (stall_cnt)
    );

    perf_counter u_redir (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (redirect),
        .o_count (redir_cnt)
    );

    assign pc       = r_pc;
    assign id_pc    = r_id_pc;
    assign id_ir    = r_id_ir;
    assign id_valid = r_id_valid;
    assign halted   = (r_state == ST_HALTED);
endmodule

// File: tb/tb_if_stage.sv
// Directed + randomized bench for if_stage against a cycle-level reference model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        go = 1'b0;
    logic [31:0] imem_data;
    logic [31:0] pc, id_pc, id_ir, cyc_cnt, stall_cnt, redir_cnt;
    logic        id_valid, halted;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_pc, m_id_pc, m_id_ir, m_cyc, m_stall, m_redir;
    bit          m_valid, m_halted;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    assign imem_data = rom(pc);

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .halt_req(halt_req), .go(go), .imem_data(imem_data),
        .pc(pc), .id_pc(id_pc), .id_ir(id_ir), .id_valid(id_valid),
        .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
        .redir_cnt(redir_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the rules of one clock edge to the reference, in priority order.
    task automatic model_edge(input bit r, input bit rd, input logic [31:0] rpc,
                              input bit st, input bit hr, input bit g);
        bit running;
        running = !m_halted;
        if (r) begin
            m_pc = 32'h0; m_id_pc = 32'h0; m_id_ir = 32'h0; m_valid = 0;
            m_halted = 0; m_cyc = 0; m_stall = 0; m_redir = 0;
            return;
        end
        if (running) m_cyc++;
        if (running && st && !rd) m_stall++;
        if (rd) m_redir++;
        if (rd) begin
            m_pc = rpc; m_id_ir = 32'h0; m_valid = 0; m_halted = 0;
        end else if (!running) begin
            if (g) m_halted = 0;
        end else if (st) begin
            // frozen
        end else if (hr) begin
            m_halted = 1; m_valid = 0; m_id_ir = 32'h0;
        end else begin
            m_id_pc = m_pc; m_id_ir = rom(m_pc); m_valid = 1; m_pc = m_pc + 1;
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("id_pc", id_pc, m_id_pc);
        chk("id_ir", id_ir, m_id_ir);
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("cyc_cnt", cyc_cnt, m_cyc);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("redir_cnt", redir_cnt, m_redir);
    endtask

    task automatic cyc(input bit r, input bit rd, input logic [31:0] rpc,
                       input bit st, input bit hr, input bit g);
        rst = r; redirect = rd; redirect_pc = rpc; stall = st; halt_req = hr; go = g;
        @(posedge clk);
        model_edge(r, rd, rpc, st, hr, g);
        #1;
        check_all();
    endtask

    logic [31:0] cyc_snap;

    initial begin
        @(negedge clk);
        // Reset with junk on every other input
        cyc(1, 1, 32'hDEAD, 1, 1, 1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("run3_pc", pc, 32'd3);
        chk("run3_id_pc", id_pc, 32'd2);
        chk("run3_id_ir", id_ir, 32'h102);
        chk("run3_cyc", cyc_cnt, 32'd3);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0, 0);
        chk("stall_pc", pc, 32'd5);
        chk("stall_cnt2", stall_cnt, 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("resume_id_pc", id_pc, 32'd5);
        // Redirect beats a simultaneous stall
        cyc(0, 1, 32'h40, 1, 0, 0);
        chk("redir_pc", pc, 32'h40);
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_cnt1", redir_cnt, 32'd1);
        chk("redir_stall_cnt", stall_cnt, 32'd2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("redir_id_ir", id_ir, 32'h140);
        // Halt at pc=9, idle, then go
        cyc(0, 1, 32'd9, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("halt_halted", 32'(halted), 32'h1);
        cyc_snap = cyc_cnt;
        repeat (10) cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
        chk("halt_pc", pc, 32'd9);
        chk("halt_cyc_frozen", cyc_cnt, cyc_snap);
        cyc(0, 0, 0, 0, 0, 1);
        chk("go_halted", 32'(halted), 32'h0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("go_id_pc", id_pc, 32'd9);
        chk("go_valid", 32'(id_valid), 32'h1);
        // halt_req loses to redirect and to stall
        cyc(0, 1, 32'h80, 0, 1, 0);
        chk("hr_redir_halted", 32'(halted), 32'h0);
        chk("hr_redir_pc", pc, 32'h80);
        cyc(0, 0, 0, 1, 1, 0);
        chk("hr_stall_halted", 32'(halted), 32'h0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("hr_go_halted", 32'(halted), 32'h1);
        cyc(0, 0, 0, 0, 0, 1);
        // PC wrap
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFF);
        // Reset while halted
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 1);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_cyc", cyc_cnt, 32'h0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                              : $urandom;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, tgt,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
